// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator.
package spi_pkg;

    localparam int SPI_BYTE_W          = 8;
    localparam int SPI_CNT_W           = $clog2(SPI_BYTE_W);
    localparam int SPI_CLK_DIV_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        WAIT,
        HOLD,
        DESEL
    } spi_state_e;

endpackage

// File: rtl/spi_clk_tick.sv
// Phase timer: tick marks the last cycle of a CLK_DIV-long phase; restart
// re-aligns the count on every FSM state change.
module spi_clk_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= 8'd0;
        else if (restart || tick)
            cnt <= 8'd0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: byte stream in/out, ss framed by tx_last.
// Build option SPI_INITIATOR_LOOPBACK_EN feeds the mosi register into the receive shifter.
module spi_initiator
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_last,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);

    spi_state_e            state, state_nx;
    logic                  tick, restart, acc, last_q, sample_in, last_bit;
    logic [SPI_CNT_W-1:0]  bit_cnt;
    logic [SPI_BYTE_W-1:0] tx_sh, rx_sh;

    assign acc      = tx_valid && tx_ready;
    assign restart  = (state_nx != state);
    assign last_bit = (bit_cnt == SPI_CNT_W'(SPI_BYTE_W - 1));
    // mosi is the shifter MSB itself, so it is a flop output and loads with the byte
    assign mosi     = tx_sh[SPI_BYTE_W-1];

`ifdef SPI_INITIATOR_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign sample_in   = tx_sh[SPI_BYTE_W-1];
`else
    assign sample_in   = miso;
`endif

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (acc)  state_nx = SETUP;
            SETUP: if (tick) state_nx = LOW;
            LOW:   if (tick) state_nx = HIGH;
            HIGH:  if (tick) state_nx = !last_bit ? LOW : (last_q ? HOLD : WAIT);
            WAIT:  if (acc)  state_nx = LOW;
            HOLD:  if (tick) state_nx = DESEL;
            DESEL: if (tick) state_nx = IDLE;
            default:         state_nx = IDLE;
        endcase
    end

    // Pin-level outputs are decoded from the next state so they flip with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk     <= 1'b0;
            ss       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            sclk     <= (state_nx == HIGH);
            ss       <= (state_nx == IDLE) || (state_nx == DESEL);
            tx_ready <= (state_nx == IDLE) || (state_nx == WAIT);
            busy     <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            last_q   <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (acc) begin
                tx_sh   <= tx_data;
                last_q  <= tx_last;
                bit_cnt <= '0;
            end
            if (state == LOW && tick)
                rx_sh <= {rx_sh[SPI_BYTE_W-2:0], sample_in};
            if (state == HIGH && tick) begin
                if (last_bit) begin
                    rx_data  <= rx_sh;
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    tx_sh   <= {tx_sh[SPI_BYTE_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_initiator.sv
// Scoreboard bench for spi_initiator: mode-0 responder model on miso, queues of
// expected mosi/rx bytes, frame timing, back-to-back, stall and mid-frame reset.
module tb_spi_initiator;
    import spi_pkg::*;

    localparam int D = SPI_CLK_DIV_DEFAULT;
`ifdef SPI_INITIATOR_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, rx_valid, busy, sclk, ss, mosi;
    logic [7:0] rx_data;
    logic       miso = 1'b0;

    always #5 clk = ~clk;

    spi_initiator #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sclk     (sclk),
        .ss       (ss),
        .mosi     (mosi),
        .miso     (miso)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rx_model(input logic [7:0] d, input logic [7:0] m);
        return LB ? d : m;
    endfunction

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] miso_q[$];
    int         runs[$];
    int         rises = 0, pulses = 0, ss_falls = 0, idx = 0, low_run = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_acc = 8'h00;

    always @(negedge ss) ss_falls++;

    // Responder model and output monitor, both on the falling clk edge
    always @(negedge clk) begin
        if (!reset) begin
            idx = 0; low_run = 0; prev_sclk = 1'b0; mosi_acc = 8'h00; miso = 1'b0;
        end else begin
            if (ss) low_run = 0;
            else if (!sclk) low_run++;
            if (sclk && !prev_sclk) begin
                rises++;
                runs.push_back(low_run);
                low_run = 0;
                mosi_acc = {mosi_acc[6:0], mosi};
                idx++;
                if (idx == 8) begin
                    idx = 0;
                    chk("mosi_expected", exp_tx_q.size() != 0, 1);
                    if (exp_tx_q.size() != 0) chk("mosi_byte", mosi_acc, exp_tx_q.pop_front());
                    if (miso_q.size() != 0) void'(miso_q.pop_front());
                end
            end
            if (rx_valid) begin
                pulses++;
                chk("rx_expected", exp_rx_q.size() != 0, 1);
                if (exp_rx_q.size() != 0) chk("rx_data", rx_data, exp_rx_q.pop_front());
            end
            prev_sclk = sclk;
            miso = (miso_q.size() != 0) ? miso_q[0][7-idx] : 1'b0;
        end
    end

    // Leaves tx_valid high after the accept edge so callers can chain bytes
    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] m);
        int   n;
        logic acc;
        n = 0; acc = 1'b0;
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        exp_tx_q.push_back(d);
        exp_rx_q.push_back(rx_model(d, m));
        miso_q.push_back(m);
        while (!acc && n < 2000) begin
            @(negedge clk); acc = tx_ready;
            @(posedge clk); #1; n++;
        end
        chk("accept", acc, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        int n, r0, p0, f0, k, badc;
        logic prev;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_ss", ss, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset pulse while idle must not disturb ss
        f0 = ss_falls;
        reset = 1'b0;
        #1 chk("idle_rst_ss", ss, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_rst_glitch", ss_falls - f0, 0);

        // Single-byte frame: 0xA5 out, responder returns 0x3C
        r0 = rises; p0 = pulses;
        send(8'hA5, 1'b1, 8'h3C);
        tx_valid = 1'b0;
        wait_idle(n);
        chk("frame_len", n + 1, 19 * D + 1);
        chk("frame_ss", ss, 1);
        chk("frame_rises", rises - r0, 8);
        chk("frame_pulses", pulses - p0, 1);
        chk("frame_rx_hold", rx_data, rx_model(8'hA5, 8'h3C));

        // Three bytes with tx_valid held high
        r0 = rises; p0 = pulses; f0 = ss_falls;
        send(8'h01, 1'b0, 8'h81);
        send(8'h02, 1'b0, 8'h42);
        send(8'h03, 1'b1, 8'hC3);
        tx_valid = 1'b0;
        wait_idle(n);
        chk("b2b_rises", rises - r0, 24);
        chk("b2b_pulses", pulses - p0, 3);
        chk("b2b_ss_low", ss_falls - f0, 1);
        chk("b2b_gap1", runs[r0+8], D + 1);
        chk("b2b_gap2", runs[r0+16], D + 1);
        chk("b2b_inbyte_low", runs[r0+1], D);

        // Stall in WAIT between bytes
        p0 = pulses;
        send(8'h55, 1'b0, 8'h0F);
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("stall_wait_reached", tx_ready, 1);
        badc = 0;
        repeat (50) begin
            @(negedge clk);
            if (ss !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) badc++;
        end
        chk("stall_wait_hold", badc, 0);
        @(posedge clk); #1;
        send(8'hAA, 1'b1, 8'hF0);
        tx_valid = 1'b0;
        wait_idle(n);
        chk("stall_pulses", pulses - p0, 2);
        chk("stall_idle", busy, 0);

        // Reset at the 4th sclk rise of a frame
        send(8'h96, 1'b1, 8'h5A);
        tx_valid = 1'b0;
        k = 0; n = 0; prev = sclk;
        while (k < 4 && n < 500) begin
            @(posedge clk); #1; n++;
            if (sclk && !prev) k++;
            prev = sclk;
        end
        chk("midrst_reach", k, 4);
        p0 = pulses;
        reset = 1'b0;
        #1;
        chk("midrst_ss", ss, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        exp_tx_q.delete(); exp_rx_q.delete(); miso_q.delete();
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_rx", pulses - p0, 0);
        send(8'h3C, 1'b1, 8'hA5);
        tx_valid = 1'b0;
        wait_idle(n);
        chk("midrst_next_len", n + 1, 19 * D + 1);
        chk("midrst_next_pulses", pulses - p0, 1);
        chk("midrst_next_rx", rx_data, rx_model(8'h3C, 8'hA5));

`ifdef SPI_INITIATOR_LOOPBACK_EN
        // miso held at 0 by the responder model, data must come back from mosi
        send(8'hC3, 1'b1, 8'h00);
        tx_valid = 1'b0;
        wait_idle(n);
        chk("loopback_rx", rx_data, 8'hC3);
`endif

        chk("scoreboard_empty", exp_rx_q.size() + exp_tx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_initiator.md
# spi_initiator

SPI initiator (master) that drives the FPGA-side serial link as the controlling end. It generates `sclk`/`ss`/`mosi`, samples `miso`, and exchanges bytes with fabric logic over a valid/ready byte stream. It is the counterpart of the existing byte-level SPI responder on the `io0`/`io1`/`dcs`/`dsck` pins, and is used for loop tests and for driving external SPI peripherals from `clk8`.

## Interface
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send, MSB first.
- `tx_last`  in  1  qualifies `tx_data`; this byte ends the frame.
- `tx_valid`  in  1  `tx_data`/`tx_last` are valid.
- `tx_ready`  out  1  initiator accepts a byte this cycle.
- `rx_data`  out  8  last received byte; held until the next byte completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates; there is no backpressure.
- `busy`  out  1  high whenever the state is not IDLE.
- `sclk`  out  1  serial clock, idle low.
- `ss`  out  1  slave select, active low.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; the bench drives it synchronously to `clk`.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0):
  - `mosi` is valid before the first rising edge and changes only after falling edges.
  - `miso` is sampled on the `clk` cycle in which `sclk` rises.
- A byte is accepted when `tx_valid && tx_ready`. The byte loads into the shift register and `tx_last` is latched.
- States:
  - IDLE: `ss`=1, `tx_ready`=1. On accept → SETUP.
  - SETUP: `ss`=0, `sclk`=0, `mosi`=bit7. Lasts CLK_DIV cycles → LOW.
  - LOW: `sclk`=0 for CLK_DIV cycles → HIGH. `miso` is sampled on entry to HIGH.
  - HIGH: `sclk`=1 for CLK_DIV cycles.
    - If the bit count is < 8: shift, drive the next `mosi` bit → LOW.
    - After the 8th bit: `rx_valid` pulses and `rx_data` is updated. Go to HOLD if the latched last flag is set, else WAIT.
  - WAIT: `ss`=0, `sclk`=0, `tx_ready`=1. On accept, load the byte and go directly to LOW; `mosi` updates with the load. The minimum WAIT is 1 cycle. WAIT may last indefinitely.
  - HOLD: `ss`=0, `sclk`=0 for CLK_DIV cycles → DESEL.
  - DESEL: `ss`=1 for CLK_DIV cycles → IDLE. `tx_ready`=0 in this state.
- `tx_ready` is high only in IDLE and WAIT.
- An internal bit counter runs 0..7. A divider counter runs 0..CLK_DIV-1 and reloads on every state change.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (async).
  - The partial byte is discarded and no `rx_valid` is produced.

## Timing
- Reset values: `sclk`=0, `ss`=1, `mosi`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0x00, `busy`=0.
- All outputs are registered.
- Single-byte frame, measured from the accept cycle to IDLE: CLK_DIV·(1+16+1+1) + 1 cycles.
  - CLK_DIV=2 gives 39 cycles.
- `rx_valid` is asserted in the cycle after the 8th HIGH phase ends.
- Back-to-back bytes with `tx_valid` held high: gap between bytes = CLK_DIV (LOW) + 1 WAIT cycle. `ss` stays low throughout.

## Configuration
- `SPI_INITIATOR_LOOPBACK_EN`:
  - Defined: the sampled input is the internal `mosi` register instead of `miso`, so `rx_data` equals the byte sent. The `miso` pin is ignored.
  - Undefined: `miso` is sampled normally.
  - Pin behaviour is identical in both builds.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, SETUP, LOW, HIGH, WAIT, HOLD, DESEL)
  - `SPI_BYTE_W`=8
  - `SPI_CLK_DIV_DEFAULT`=2
- Sub-module `spi_clk_tick`: divider counter with `restart` input, asserting `tick` when CLK_DIV cycles have elapsed.
- Top-level FSM, shift registers and bit counter live in `spi_initiator`.

## Test plan
- Reset → all outputs equal their reset values. Assert reset again while idle → no glitch on `ss`.
- CLK_DIV=2, send 0xA5 with `tx_last`=1, `miso` model returns 0x3C:
  - `mosi` at the rising edges = 1,0,1,0,0,1,0,1
  - exactly 8 `sclk` rising edges
  - `rx_data`=0x3C with a single `rx_valid` pulse
  - `ss` high 39 cycles after accept
- 3-byte frame (0x01, 0x02, 0x03 last) with `tx_valid` held high → `ss` stays low for all 24 edges, 3 `rx_valid` pulses, each inter-byte gap is 3 cycles.
- Stall: byte 0x55 not last, then `tx_valid`=0 for 50 cycles → WAIT holds `ss`=0, `sclk`=0, `tx_ready`=1. Then send 0xAA last → completes normally.
- Reset asserted at the 4th `sclk` rise → `ss`=1 and `sclk`=0 asynchronously, no `rx_valid`. The next frame works correctly.
- With `SPI_INITIATOR_LOOPBACK_EN`, send 0xC3 with `miso` tied to 0 → `rx_data`=0xC3.
